// File: rtl/alu_op_sequencer.sv
// Command sequencer that feeds operands from a 4x16 register file to an external ALU
// and writes the result and flags back after a fixed one-cycle settle window.
module alu_op_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_kind,
  input  logic [2:0]  cmd_opc,
  input  logic [1:0]  cmd_ra,
  input  logic [1:0]  cmd_rb,
  input  logic [1:0]  cmd_rd,
  input  logic [15:0] cmd_imm,
  input  logic        cmd_use_carry,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_ci,
  output logic [2:0]  alu_opc,
  input  logic [15:0] alu_w,
  input  logic        alu_co,
  input  logic        alu_zr,
  input  logic [1:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic        res_valid,
  output logic [15:0] res_data,
  output logic        flag_c,
  output logic        flag_z
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] regs_q [4];
  logic [15:0] regs_d [4];
  logic [1:0]  rd_q;
  logic [15:0] alu_a_q, alu_b_q, res_data_q;
  logic        alu_ci_q, flag_c_q, flag_z_q, res_valid_q;
  logic [2:0]  alu_opc_q;
  logic        accept_s, alu_accept_s, load_accept_s;

  assign accept_s      = cmd_valid & cmd_ready;
  assign alu_accept_s  = accept_s & ~cmd_kind;
  assign load_accept_s = accept_s & cmd_kind;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; ISSUE is a fixed single settle cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (alu_accept_s) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: state_d = ST_CAPT;
      ST_CAPT:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    cmd_ready = 1'b0;
    if (state_q == ST_IDLE) begin
      cmd_ready = 1'b1;
    end else begin
      cmd_ready = 1'b0;
    end
  end

  // Register-file write selection; loads and captures never coincide
  always_comb begin
    regs_d = regs_q;
    if (state_q == ST_CAPT) begin
      regs_d[rd_q] = alu_w;
    end else if (load_accept_s) begin
      regs_d[cmd_rd] = cmd_imm;
    end else begin
      regs_d = regs_q;
    end
  end

  // Register-file storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= 16'h0000;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Operand issue, result capture and flag update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q     <= 16'h0000;
      alu_b_q     <= 16'h0000;
      alu_ci_q    <= 1'b0;
      alu_opc_q   <= 3'd0;
      rd_q        <= 2'd0;
      res_data_q  <= 16'h0000;
      res_valid_q <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_z_q    <= 1'b0;
    end else begin
      if (alu_accept_s) begin
        alu_a_q   <= regs_q[cmd_ra];
        alu_b_q   <= regs_q[cmd_rb];
        alu_ci_q  <= cmd_use_carry ? flag_c_q : 1'b0;
        alu_opc_q <= cmd_opc;
        rd_q      <= cmd_rd;
      end
      if (state_q == ST_CAPT) begin
        res_data_q <= alu_w;
        flag_c_q   <= alu_co;
        flag_z_q   <= alu_zr;
      end
      res_valid_q <= (state_q == ST_CAPT);
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_ci    = alu_ci_q;
  assign alu_opc   = alu_opc_q;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign flag_c    = flag_c_q;
  assign flag_z    = flag_z_q;
  assign rd_data   = regs_q[rd_addr];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed plus randomized bench for alu_op_sequencer; the bench plays the ALU and keeps
// a transaction-level model of registers, flags and issued operands.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_kind = 1'b0;
  logic [2:0]  cmd_opc = 3'd0;
  logic [1:0]  cmd_ra = 2'd0, cmd_rb = 2'd0, cmd_rd = 2'd0;
  logic [15:0] cmd_imm = 16'h0000;
  logic        cmd_use_carry = 1'b0;
  logic [15:0] alu_a, alu_b;
  logic        alu_ci;
  logic [2:0]  alu_opc;
  logic [15:0] alu_w = 16'h0000;
  logic        alu_co = 1'b0, alu_zr = 1'b0;
  logic [1:0]  rd_addr = 2'd0;
  logic [15:0] rd_data;
  logic        res_valid;
  logic [15:0] res_data;
  logic        flag_c, flag_z;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] m_regs [4];
  logic        m_fc, m_fz, m_ci;
  logic [15:0] m_a, m_b, m_res;
  logic [2:0]  m_opc;

  logic [2:0]  r_opc;
  logic [1:0]  r_ra, r_rb, r_rd;
  logic [15:0] r_w;
  logic        r_uc, r_co, r_zr;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
    .cmd_opc(cmd_opc), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
    .cmd_imm(cmd_imm), .cmd_use_carry(cmd_use_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci), .alu_opc(alu_opc),
    .alu_w(alu_w), .alu_co(alu_co), .alu_zr(alu_zr),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .res_valid(res_valid), .res_data(res_data),
    .flag_c(flag_c), .flag_z(flag_z)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reg(input logic [1:0] r, input string tag);
    rd_addr = r;
    #1;
    chk(tag, {16'h0000, rd_data}, {16'h0000, m_regs[r]});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 16'h0000;
    m_fc = 1'b0; m_fz = 1'b0; m_ci = 1'b0;
    m_a = 16'h0000; m_b = 16'h0000; m_res = 16'h0000; m_opc = 3'd0;
  endtask

  task automatic check_issued(input string tag);
    chk({tag, "_a"}, {16'h0000, alu_a}, {16'h0000, m_a});
    chk({tag, "_b"}, {16'h0000, alu_b}, {16'h0000, m_b});
    chk({tag, "_ci"}, {31'd0, alu_ci}, {31'd0, m_ci});
    chk({tag, "_opc"}, {29'd0, alu_opc}, {29'd0, m_opc});
  endtask

  task automatic do_load(input logic [1:0] rd, input logic [15:0] imm);
    chk("ld_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_kind = 1'b1; cmd_rd = rd; cmd_imm = imm;
    cmd_ra = 2'($urandom); cmd_rb = 2'($urandom); cmd_opc = 3'($urandom);
    tick();
    cmd_valid = 1'b0;
    m_regs[rd] = imm;
    check_issued("ld_hold");
    chk("ld_fc", {31'd0, flag_c}, {31'd0, m_fc});
    chk("ld_fz", {31'd0, flag_z}, {31'd0, m_fz});
    chk("ld_resv", {31'd0, res_valid}, 32'd0);
    check_reg(rd, "ld_reg");
  endtask

  task automatic do_alu(input logic [2:0] opc, input logic [1:0] ra, input logic [1:0] rb,
                        input logic [1:0] rd, input logic uc, input logic [15:0] w,
                        input logic co, input logic zr);
    chk("op_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_kind = 1'b0; cmd_opc = opc; cmd_ra = ra; cmd_rb = rb;
    cmd_rd = rd; cmd_use_carry = uc; cmd_imm = 16'($urandom);
    m_a = m_regs[ra]; m_b = m_regs[rb]; m_opc = opc; m_ci = uc ? m_fc : 1'b0;
    tick();
    cmd_valid = 1'b0; cmd_ra = 2'($urandom); cmd_rb = 2'($urandom); cmd_opc = 3'($urandom);
    check_issued("op_issue");
    chk("op_busy1", {31'd0, cmd_ready}, 32'd0);
    alu_w = w; alu_co = co; alu_zr = zr;
    tick();
    chk("op_busy2", {31'd0, cmd_ready}, 32'd0);
    chk("op_resv_early", {31'd0, res_valid}, 32'd0);
    check_issued("op_hold");
    tick();
    m_regs[rd] = w; m_fc = co; m_fz = zr; m_res = w;
    chk("op_resv", {31'd0, res_valid}, 32'd1);
    chk("op_ready_done", {31'd0, cmd_ready}, 32'd1);
    chk("op_res", {16'h0000, res_data}, {16'h0000, m_res});
    chk("op_fc", {31'd0, flag_c}, {31'd0, m_fc});
    chk("op_fz", {31'd0, flag_z}, {31'd0, m_fz});
    check_reg(rd, "op_wb");
    alu_w = 16'($urandom); alu_co = 1'($urandom); alu_zr = 1'($urandom);
    tick();
    chk("op_resv_fall", {31'd0, res_valid}, 32'd0);
    chk("op_res_hold", {16'h0000, res_data}, {16'h0000, m_res});
    chk("op_fc_hold", {31'd0, flag_c}, {31'd0, m_fc});
    check_issued("op_idle_hold");
  endtask

  initial begin
    model_reset();
    tick();
    tick();
    check_issued("rst");
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_resv", {31'd0, res_valid}, 32'd0);
    chk("rst_res", {16'h0000, res_data}, 32'd0);
    chk("rst_fc", {31'd0, flag_c}, 32'd0);
    chk("rst_fz", {31'd0, flag_z}, 32'd0);
    for (int i = 0; i < 4; i++) check_reg(2'(i), "rst_reg");
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    tick();

    // back-to-back loads, then the basic op, carry reuse and zero result
    do_load(2'd0, 16'h1234);
    do_load(2'd1, 16'hFFFF);
    check_reg(2'd0, "ld_r0");
    check_reg(2'd1, "ld_r1");
    do_alu(3'd2, 2'd0, 2'd1, 2'd2, 1'b0, 16'hAAAA, 1'b1, 1'b0);
    do_alu(3'd2, 2'd0, 2'd1, 2'd2, 1'b1, 16'h5555, 1'b1, 1'b0);
    do_alu(3'd5, 2'd2, 2'd2, 2'd3, 1'b1, 16'h0000, 1'b0, 1'b1);

    // load held valid while busy must wait for IDLE and happen once
    cmd_valid = 1'b1; cmd_kind = 1'b0; cmd_opc = 3'd1; cmd_ra = 2'd0; cmd_rb = 2'd1;
    cmd_rd = 2'd1; cmd_use_carry = 1'b0;
    m_a = m_regs[0]; m_b = m_regs[1]; m_opc = 3'd1; m_ci = 1'b0;
    tick();
    cmd_kind = 1'b1; cmd_rd = 2'd0; cmd_imm = 16'hBEEF;
    chk("hold_busy1", {31'd0, cmd_ready}, 32'd0);
    alu_w = 16'h0F0F; alu_co = 1'b0; alu_zr = 1'b0;
    tick();
    chk("hold_busy2", {31'd0, cmd_ready}, 32'd0);
    check_reg(2'd0, "hold_r0_capt");
    tick();
    m_regs[1] = 16'h0F0F; m_fc = 1'b0; m_fz = 1'b0; m_res = 16'h0F0F;
    chk("hold_idle", {31'd0, cmd_ready}, 32'd1);
    chk("hold_resv", {31'd0, res_valid}, 32'd1);
    check_reg(2'd0, "hold_r0_pre");
    check_reg(2'd1, "hold_r1_wb");
    tick();
    cmd_valid = 1'b0; cmd_imm = 16'h1111;
    m_regs[0] = 16'hBEEF;
    check_reg(2'd0, "hold_r0_ld");
    check_issued("hold_alu");
    tick();
    check_reg(2'd0, "hold_r0_once");
    chk("hold_resv_fall", {31'd0, res_valid}, 32'd0);

    // full register aliasing
    do_load(2'd3, 16'h0001);
    do_alu(3'd0, 2'd3, 2'd3, 2'd3, 1'b0, 16'h0002, 1'b0, 1'b0);
    check_reg(2'd3, "alias_r3");

    for (int n = 0; n < 40; n++) begin
      r_opc = 3'($urandom); r_ra = 2'($urandom); r_rb = 2'($urandom); r_rd = 2'($urandom);
      r_uc = 1'($urandom); r_co = 1'($urandom);
      r_w = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      r_zr = (r_w == 16'h0000);
      if ($urandom_range(0, 2) == 0) do_load(r_rd, r_w);
      else do_alu(r_opc, r_ra, r_rb, r_rd, r_uc, r_w, r_co, r_zr);
    end
    for (int i = 0; i < 4; i++) check_reg(2'(i), "rand_final");

    // reset asserted mid-operation aborts the write-back
    do_load(2'd2, 16'hC3C3);
    do_alu(3'd4, 2'd2, 2'd2, 2'd0, 1'b0, 16'h8001, 1'b1, 1'b0);
    cmd_valid = 1'b1; cmd_kind = 1'b0; cmd_opc = 3'd7; cmd_ra = 2'd0; cmd_rb = 2'd2;
    cmd_rd = 2'd2; cmd_use_carry = 1'b1;
    tick();
    cmd_valid = 1'b0;
    alu_w = 16'h5A5A; alu_co = 1'b1; alu_zr = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_issued("arst");
    chk("arst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("arst_resv", {31'd0, res_valid}, 32'd0);
    chk("arst_res", {16'h0000, res_data}, 32'd0);
    chk("arst_fc", {31'd0, flag_c}, 32'd0);
    chk("arst_fz", {31'd0, flag_z}, 32'd0);
    check_reg(2'd2, "arst_r2");
    tick();
    tick();
    chk("arst_resv_late", {31'd0, res_valid}, 32'd0);
    check_reg(2'd2, "arst_r2_late");
    rst_n = 1'b1;
    #1;
    chk("arst_release_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    do_load(2'd1, 16'h00FF);
    do_alu(3'd3, 2'd1, 2'd2, 2'd2, 1'b1, 16'h7E00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) check_reg(2'(i), "end_reg");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
